// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: TSC opcode fields, BTB counter
// encodings and the control-class decode used by resolve and update.
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  typedef enum logic [2:0] {
    CTRL_NONE,
    CTRL_BRANCH,
    CTRL_JUMP,
    CTRL_JUMPREG,
    CTRL_HALT
  } ctrl_e;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RRR = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_HLT = 6'd29;

  function automatic ctrl_e ctrl_class(input logic [3:0] op, input logic [5:0] fn);
    ctrl_e cls;
    cls = CTRL_NONE;
    if (op == OP_RRR) begin
      if (fn == FN_JPR || fn == FN_JRL) cls = CTRL_JUMPREG;
      else if (fn == FN_HLT)            cls = CTRL_HALT;
    end else if (op == OP_BNE || op == OP_BEQ || op == OP_BGZ || op == OP_BLZ) begin
      cls = CTRL_BRANCH;
    end else if (op == OP_JMP || op == OP_JAL) begin
      cls = CTRL_JUMP;
    end
    return cls;
  endfunction

  function automatic logic ctr_predicts_taken(input ctr_e c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF/EX-facing signal bundle of the branch predict unit. The pipeline drives
// through the master modport; the predictor consumes the slave modport.
interface branch_predict_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int STAT_W    = 16
);
  logic [WORD_SIZE-1:0] if_pc;
  logic [WORD_SIZE-1:0] if_pred_pc;
  logic                 ex_valid;
  logic                 ex_stall;
  logic [WORD_SIZE-1:0] ex_pc;
  logic [WORD_SIZE-1:0] ex_inst;
  logic [WORD_SIZE-1:0] ex_a;
  logic [WORD_SIZE-1:0] ex_b;
  logic [WORD_SIZE-1:0] ex_pred_pc;
  logic [WORD_SIZE-1:0] ex_real_pc;
  logic                 ex_mispredict;
  logic [STAT_W-1:0]    stat_ctrl;
  logic [STAT_W-1:0]    stat_miss;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_pc, ex_inst, ex_a, ex_b, ex_pred_pc,
    input  if_pred_pc, ex_real_pc, ex_mispredict, stat_ctrl, stat_miss
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_pc, ex_inst, ex_a, ex_b, ex_pred_pc,
    output if_pred_pc, ex_real_pc, ex_mispredict, stat_ctrl, stat_miss
  );
endinterface

// File: rtl/branch_predict_unit_btb_ram.sv
// Direct-mapped BTB entry array: combinational lookup read port for IF, and a
// read/write update port for EX. Sync reset clears valid bits and counters.
module bpu_btb_ram
  import branch_predict_unit_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_W    = 12,
  parameter int TGT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] lk_idx,
  output logic                lk_valid,
  output logic [TAG_W-1:0]    lk_tag,
  output logic [TGT_W-1:0]    lk_target,
  output ctr_e                lk_ctr,
  input  logic [IDX_BITS-1:0] up_idx,
  output logic                up_valid,
  output logic [TAG_W-1:0]    up_tag,
  output logic [TGT_W-1:0]    up_target,
  output ctr_e                up_ctr,
  input  logic                wr_en,
  input  logic                wr_valid,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [TGT_W-1:0]    wr_target,
  input  ctr_e                wr_ctr
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic             valid_q  [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TGT_W-1:0] target_q [ENTRIES];

  // Reads are pre-update: a same-cycle write becomes visible next cycle.
  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign lk_ctr    = ctr_q[lk_idx];

  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= wr_valid;
      ctr_q[up_idx]   <= wr_ctr;
    end
  end

  // Tag/target carry no reset; a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_q[up_idx]    <= wr_tag;
      target_q[up_idx] <= wr_target;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage next-PC resolver with a direct-mapped BTB feeding IF predictions.
// Optional performance counters are built when BPU_STATS_EN is defined.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 4,
  parameter int STAT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  branch_predict_unit_if.slave bpu
);
  localparam int TAG_W = WORD_SIZE - IDX_BITS;
  localparam logic signed [WORD_SIZE-1:0] ZERO_S = '0;

  function automatic ctr_e sat_inc(input ctr_e c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

  logic                 lk_valid, up_valid;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic [WORD_SIZE-1:0] lk_target, up_target;
  ctr_e                 lk_ctr, up_ctr;

  logic                 wr_en, wr_valid;
  logic [WORD_SIZE-1:0] wr_target;
  ctr_e                 wr_ctr;

  logic [3:0]           op;
  logic [5:0]           fn;
  ctrl_e                cls;
  logic signed [WORD_SIZE-1:0] a_s;
  logic [WORD_SIZE-1:0] pc_inc, br_off;
  logic                 br_taken, lk_hit, up_hit, upd_en;
  logic [WORD_SIZE-1:0] real_pc;

  bpu_btb_ram #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W),
    .TGT_W    (WORD_SIZE)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lk_idx    (bpu.if_pc[IDX_BITS-1:0]),
    .lk_valid  (lk_valid),
    .lk_tag    (lk_tag),
    .lk_target (lk_target),
    .lk_ctr    (lk_ctr),
    .up_idx    (bpu.ex_pc[IDX_BITS-1:0]),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr),
    .wr_en     (wr_en),
    .wr_valid  (wr_valid),
    .wr_tag    (bpu.ex_pc[WORD_SIZE-1:IDX_BITS]),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // IF lookup
  assign lk_hit = lk_valid && (lk_tag == bpu.if_pc[WORD_SIZE-1:IDX_BITS]);
  assign bpu.if_pred_pc = (lk_hit && ctr_predicts_taken(lk_ctr)) ? lk_target
                                                                  : bpu.if_pc + WORD_SIZE'(1);

  // EX resolve
  assign op     = bpu.ex_inst[WORD_SIZE-1 -: 4];
  assign fn     = bpu.ex_inst[5:0];
  assign cls    = ctrl_class(op, fn);
  assign a_s    = bpu.ex_a;
  assign pc_inc = bpu.ex_pc + WORD_SIZE'(1);
  assign br_off = {{(WORD_SIZE-8){bpu.ex_inst[7]}}, bpu.ex_inst[7:0]};

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BNE:  br_taken = (bpu.ex_a != bpu.ex_b);
      OP_BEQ:  br_taken = (bpu.ex_a == bpu.ex_b);
      OP_BGZ:  br_taken = (a_s > ZERO_S);
      OP_BLZ:  br_taken = bpu.ex_a[WORD_SIZE-1];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    real_pc = pc_inc;
    case (cls)
      CTRL_BRANCH:  real_pc = br_taken ? pc_inc + br_off : pc_inc;
      CTRL_JUMP:    real_pc = {bpu.ex_pc[WORD_SIZE-1:12], bpu.ex_inst[11:0]};
      CTRL_JUMPREG: real_pc = bpu.ex_a;
      CTRL_HALT:    real_pc = bpu.ex_pc;
      default:      real_pc = pc_inc;
    endcase
  end

  assign bpu.ex_real_pc    = real_pc;
  assign bpu.ex_mispredict = bpu.ex_valid && (cls != CTRL_HALT) && (real_pc != bpu.ex_pred_pc);

  // BTB update policy; reset priority is enforced inside the array
  assign upd_en = bpu.ex_valid && !bpu.ex_stall;
  assign up_hit = up_valid && (up_tag == bpu.ex_pc[WORD_SIZE-1:IDX_BITS]);

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_target = real_pc;
    wr_ctr    = up_ctr;
    case (cls)
      CTRL_BRANCH: begin
        if (br_taken) begin
          wr_en  = upd_en;
          wr_ctr = up_hit ? sat_inc(up_ctr) : WT;
        end else if (up_hit) begin
          wr_en     = upd_en;
          wr_target = up_target;
          wr_ctr    = sat_dec(up_ctr);
        end
      end
      CTRL_JUMP, CTRL_JUMPREG: begin
        wr_en  = upd_en;
        wr_ctr = ST;
      end
      CTRL_NONE: begin
        // A non-control instruction aliasing a live entry means the entry is stale.
        if (up_hit) begin
          wr_en     = upd_en;
          wr_valid  = 1'b0;
          wr_target = up_target;
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

`ifdef BPU_STATS_EN
  logic              is_ctrl;
  logic [STAT_W-1:0] stat_ctrl_q, stat_miss_q;

  assign is_ctrl = (cls == CTRL_BRANCH) || (cls == CTRL_JUMP) || (cls == CTRL_JUMPREG);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ctrl_q <= '0;
      stat_miss_q <= '0;
    end else if (upd_en && is_ctrl) begin
      if (~&stat_ctrl_q) stat_ctrl_q <= stat_ctrl_q + STAT_W'(1);
      if (bpu.ex_mispredict && ~&stat_miss_q) stat_miss_q <= stat_miss_q + STAT_W'(1);
    end
  end

  assign bpu.stat_ctrl = stat_ctrl_q;
  assign bpu.stat_miss = stat_miss_q;
`else
  assign bpu.stat_ctrl = '0;
  assign bpu.stat_miss = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit against an array-based
// reference model of the BTB and next-PC rules.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.WORD_SIZE(16), .STAT_W(16)) bpu ();

  branch_predict_unit #(.WORD_SIZE(16), .IDX_BITS(4), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bpu   (bpu)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  bit          m_valid [16];
  logic [11:0] m_tag   [16];
  logic [15:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_sctrl, m_smiss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_sctrl = 0;
    m_smiss = 0;
  endtask

  // 0 = plain, 1 = conditional branch, 2 = jump (direct or register), 3 = halt
  function automatic int kind_of(input logic [15:0] inst);
    if (inst[15:12] == 4'hF) begin
      if (inst[5:0] == 6'd25 || inst[5:0] == 6'd26) return 2;
      if (inst[5:0] == 6'd29) return 3;
      return 0;
    end
    if (inst[15:12] <= 4'd3) return 1;
    if (inst[15:12] == 4'd9 || inst[15:12] == 4'd10) return 2;
    return 0;
  endfunction

  function automatic bit is_taken(input logic [15:0] inst, input logic [15:0] a, input logic [15:0] b);
    case (inst[15:12])
      4'd0:    return a != b;
      4'd1:    return a == b;
      4'd2:    return (a[15] == 1'b0) && (a != 16'd0);
      4'd3:    return a[15];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [15:0] inst,
                                           input logic [15:0] a, input logic [15:0] b);
    int k, off;
    logic [7:0] imm;
    k = kind_of(inst);
    imm = inst[7:0];
    if (k == 3) return pc;
    if (k == 2 && inst[15:12] == 4'hF) return a;
    if (k == 2) return {pc[15:12], inst[11:0]};
    if (k == 1 && is_taken(inst, a, b)) begin
      off = (imm >= 8'd128) ? int'(imm) - 256 : int'(imm);
      return 16'((int'(pc) + 1 + off) & 32'hFFFF);
    end
    return 16'((int'(pc) + 1) & 32'hFFFF);
  endfunction

  function automatic logic [15:0] model_pred(input logic [15:0] ipc);
    int i;
    i = int'(ipc[3:0]);
    if (m_valid[i] && m_tag[i] == ipc[15:4] && m_ctr[i] >= 2) return m_tgt[i];
    return 16'((int'(ipc) + 1) & 32'hFFFF);
  endfunction

  task automatic model_update(input logic [15:0] pc, input logic [15:0] inst,
                              input logic [15:0] a, input logic [15:0] b, input bit mis);
    int i, k;
    bit hit;
    logic [15:0] nxt;
    i = int'(pc[3:0]);
    k = kind_of(inst);
    hit = m_valid[i] && (m_tag[i] == pc[15:4]);
    nxt = ref_next(pc, inst, a, b);
    if (k == 1) begin
      if (is_taken(inst, a, b)) begin
        if (hit) begin
          m_tgt[i] = nxt;
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        end else begin
          m_valid[i] = 1'b1; m_tag[i] = pc[15:4]; m_tgt[i] = nxt; m_ctr[i] = 2;
        end
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (k == 2) begin
      m_valid[i] = 1'b1; m_tag[i] = pc[15:4]; m_tgt[i] = nxt; m_ctr[i] = 3;
    end else if (k == 0 && hit) begin
      m_valid[i] = 1'b0;
    end
`ifdef BPU_STATS_EN
    if (k == 1 || k == 2) begin
      if (m_sctrl < 65535) m_sctrl++;
      if (mis && m_smiss < 65535) m_smiss++;
    end
`else
    if (mis) m_smiss = m_smiss;
`endif
  endtask

  // One cycle: drive, check combinational outputs, clock, update model, check stats.
  task automatic step(input logic [15:0] ipc, input int want_pred,
                      input bit v, input bit st, input logic [15:0] pc, input logic [15:0] inst,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] pred,
                      input int want_real, input int want_mis);
    logic [15:0] exp_real;
    bit exp_mis;
    bpu.if_pc = ipc; bpu.ex_valid = v; bpu.ex_stall = st; bpu.ex_pc = pc;
    bpu.ex_inst = inst; bpu.ex_a = a; bpu.ex_b = b; bpu.ex_pred_pc = pred;
    #2;
    exp_real = ref_next(pc, inst, a, b);
    exp_mis  = v && (kind_of(inst) != 3) && (exp_real != pred);
    check("if_pred_pc", 32'(bpu.if_pred_pc), 32'(model_pred(ipc)));
    check("ex_real_pc", 32'(bpu.ex_real_pc), 32'(exp_real));
    check("ex_mispredict", 32'(bpu.ex_mispredict), 32'(exp_mis));
    if (want_pred >= 0) check("pred_const", 32'(bpu.if_pred_pc), 32'(want_pred));
    if (want_real >= 0) check("real_const", 32'(bpu.ex_real_pc), 32'(want_real));
    if (want_mis >= 0)  check("mis_const", 32'(bpu.ex_mispredict), 32'(want_mis));
    @(posedge clk);
    if (v && !st) model_update(pc, inst, a, b, exp_mis);
    #1;
    check("stat_ctrl", 32'(bpu.stat_ctrl), 32'(m_sctrl));
    check("stat_miss", 32'(bpu.stat_miss), 32'(m_smiss));
  endtask

  task automatic look(input logic [15:0] ipc, input int want_pred);
    step(ipc, want_pred, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, -1, -1);
  endtask

  initial begin
    logic [15:0] pc, ipc, inst, a, b, pred;
    bit v, st;
    int r;

    // 1: reset state
    reset = 1'b1;
    bpu.if_pc = 16'h0010; bpu.ex_valid = 1'b0; bpu.ex_stall = 1'b0; bpu.ex_pc = '0;
    bpu.ex_inst = '0; bpu.ex_a = '0; bpu.ex_b = '0; bpu.ex_pred_pc = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred", 32'(bpu.if_pred_pc), 32'h0011);
    check("reset_stat_ctrl", 32'(bpu.stat_ctrl), 32'h0);
    check("reset_stat_miss", 32'(bpu.stat_miss), 32'h0);
    reset = 1'b0;
    look(16'h0010, 16'h0011);
    look(16'hFFFF, 16'h0000);

    // 2: taken BEQ allocates with counter 2
    step(16'h0020, 16'h0021, 1, 0, 16'h0020, 16'h1105, 16'd3, 16'd3, 16'h0021, 16'h0026, 1);
    look(16'h0020, 16'h0026);

    // 3: three not-taken resolutions walk the counter down
    step(16'h0020, 16'h0026, 1, 0, 16'h0020, 16'h1105, 16'd3, 16'd4, 16'h0026, 16'h0021, 1);
    step(16'h0020, 16'h0021, 1, 0, 16'h0020, 16'h1105, 16'd3, 16'd4, 16'h0021, 16'h0021, 0);
    step(16'h0020, 16'h0021, 1, 0, 16'h0020, 16'h1105, 16'd3, 16'd4, 16'h0021, 16'h0021, 0);
    look(16'h0020, 16'h0021);

    // 4: indirect jump retargets; then a plain instruction clears the alias
    step(16'h0040, 16'h0041, 1, 0, 16'h0040, 16'hF019, 16'h1234, 16'h0, 16'h0041, 16'h1234, 1);
    look(16'h0040, 16'h1234);
    step(16'h0040, 16'h1234, 1, 0, 16'h0040, 16'hF019, 16'h2000, 16'h0, 16'h1234, 16'h2000, 1);
    look(16'h0040, 16'h2000);
    step(16'h0040, 16'h2000, 1, 0, 16'h0040, 16'hF000, 16'h0, 16'h0, 16'h0041, 16'h0041, 0);
    look(16'h0040, 16'h0041);

    // 5: stalled taken BNE updates once
    for (int i = 0; i < 3; i++)
      step(16'h0050, 16'h0051, 1, 1, 16'h0050, 16'h0003, 16'd1, 16'd2, 16'h0051, 16'h0054, 1);
    step(16'h0050, 16'h0051, 1, 0, 16'h0050, 16'h0003, 16'd1, 16'd2, 16'h0051, 16'h0054, 1);
    look(16'h0050, 16'h0054);
    step(16'h0050, 16'h0054, 1, 0, 16'h0050, 16'h0003, 16'd1, 16'd1, 16'h0054, 16'h0051, 1);
    look(16'h0050, 16'h0051);

    // 6: same-index lookup during update returns the old prediction
    step(16'h0103, 16'h0104, 1, 0, 16'h0103, 16'h90A0, 16'h0, 16'h0, 16'h0104, 16'h00A0, 1);
    look(16'h0103, 16'h00A0);

    // HLT never mispredicts nor updates; BGZ/BLZ sign handling
    step(16'h0060, 16'h0061, 1, 0, 16'h0060, 16'hF01D, 16'h0, 16'h0, 16'h0061, 16'h0060, 0);
    look(16'h0060, 16'h0061);
    step(16'h0030, 16'h0031, 1, 0, 16'h0030, 16'h20FE, 16'h8000, 16'h0, 16'h0031, 16'h0031, 0);
    step(16'h0030, 16'h0031, 1, 0, 16'h0030, 16'h20FE, 16'h0005, 16'h0, 16'h0031, 16'h002F, 1);
    look(16'h0030, 16'h002F);
    step(16'h0035, 16'h0036, 1, 0, 16'h0035, 16'h3002, 16'h8000, 16'h0, 16'h0036, 16'h0038, 1);

    // 7: reset wins over a pending taken update
    bpu.if_pc = 16'h0070; bpu.ex_valid = 1'b1; bpu.ex_stall = 1'b0; bpu.ex_pc = 16'h0070;
    bpu.ex_inst = 16'h1105; bpu.ex_a = 16'd3; bpu.ex_b = 16'd3; bpu.ex_pred_pc = 16'h0071;
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    look(16'h0070, 16'h0071);
    look(16'h0020, 16'h0021);
    look(16'h0103, 16'h0104);
    check("rst_stat_ctrl", 32'(bpu.stat_ctrl), 32'h0);

    // Randomized traffic over a small PC pool so entries alias and hit
    for (int n = 0; n < 400; n++) begin
      pc  = {($urandom_range(0, 1) != 0) ? 12'h001 : 12'h3A0, 4'($urandom_range(0, 15))};
      ipc = {($urandom_range(0, 1) != 0) ? 12'h001 : 12'h3A0, 4'($urandom_range(0, 15))};
      r = int'($urandom_range(0, 9));
      if (r <= 3)      inst = {4'(r), 4'($urandom), 8'($urandom)};
      else if (r == 4) inst = {4'(9 + $urandom_range(0, 1)), 12'($urandom)};
      else if (r == 5) inst = {4'hF, 6'($urandom), 6'(25 + $urandom_range(0, 1))};
      else if (r == 6) inst = {4'hF, 6'($urandom), 6'd29};
      else if (r == 7) inst = {4'(4 + $urandom_range(0, 4)), 12'($urandom)};
      else             inst = {4'hF, 6'($urandom), 6'($urandom_range(0, 7))};
      a = ($urandom_range(0, 3) == 0) ? (16'h8000 | 16'($urandom)) : 16'($urandom_range(0, 3));
      b = 16'($urandom_range(0, 3));
      pred = ($urandom_range(0, 1) != 0) ? model_pred(pc) : 16'($urandom);
      v  = ($urandom_range(0, 99) < 85);
      st = ($urandom_range(0, 99) < 20);
      step(ipc, -1, v, st, pc, inst, a, b, pred, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
